// File: rtl/qpsk_despreader.sv
// QPSK despreader: PN-correlates SPREAD chips per bit, hard-decides, packs bits MSB-first.
// Optional `DESPREAD_METRIC_EN adds o_metric, the weakest |correlation| in the current byte.
module qpsk_despreader #(
   parameter int unsigned       SPREAD   = 24,
   parameter logic [SPREAD-1:0] PN_CODE  = 24'hB38E51,
   parameter int unsigned       SAMPLE_W = 16
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic [2*SAMPLE_W-1:0] i_data,
   input  logic                  i_valid_input,
   input  logic                  i_sof,
   output logic                  o_ready,
   output logic [7:0]            o_data,
   output logic                  o_valid_output,
   input  logic                  i_ready_output,
   output logic                  o_resync
`ifdef DESPREAD_METRIC_EN
   ,
   output logic [SAMPLE_W+$clog2(SPREAD)-1:0] o_metric
`endif
);

   localparam int unsigned ACC_W = SAMPLE_W + $clog2(SPREAD) + 1;
   localparam int unsigned NSYM  = SPREAD / 2;
   localparam int unsigned SYM_W = (NSYM > 1) ? $clog2(NSYM) : 1;
   localparam logic [SYM_W-1:0] LAST_SYM = SYM_W'(NSYM - 1);

   typedef enum logic [0:0] {StIdle, StRun} state_e;

   state_e                    state_q, state_d;
   logic signed [ACC_W-1:0]   acc_q;
   logic [SYM_W-1:0]          sym_cnt_q;
   logic [2:0]                bit_cnt_q;
   logic [6:0]                shift_q;

   logic                      accept, start, process, resync_d, completing, last_sym, dec_bit;
   logic [SYM_W-1:0]          sym_eff;
   logic [2:0]                bit_base;
   logic [6:0]                byte_base;
   logic [7:0]                byte_next;
   logic                      pn_i, pn_q;
   logic signed [SAMPLE_W-1:0] samp_i, samp_q;
   logic signed [ACC_W-1:0]   ext_i, ext_q, term_i, term_q, acc_base, acc_next;

   assign completing = (state_q == StRun) && (sym_cnt_q == LAST_SYM) && (bit_cnt_q == 3'd7);
   assign o_ready    = ~(o_valid_output & ~i_ready_output) | ~completing;

   always_comb begin
      state_d  = state_q;
      accept   = i_valid_input & o_ready;
      start    = accept & i_sof;
      process  = accept & (i_sof | (state_q == StRun));
      resync_d = start & (state_q == StRun) & ((sym_cnt_q != '0) | (bit_cnt_q != 3'd0));
      if (start) state_d = StRun;

      // A frame start restarts the bit and byte from scratch.
      sym_eff   = start ? '0 : sym_cnt_q;
      bit_base  = start ? 3'd0 : bit_cnt_q;
      byte_base = start ? 7'd0 : shift_q;
      acc_base  = start ? '0 : acc_q;

      samp_i   = i_data[2*SAMPLE_W-1:SAMPLE_W];
      samp_q   = i_data[SAMPLE_W-1:0];
      ext_i    = {{(ACC_W-SAMPLE_W){samp_i[SAMPLE_W-1]}}, samp_i};
      ext_q    = {{(ACC_W-SAMPLE_W){samp_q[SAMPLE_W-1]}}, samp_q};
      pn_i     = PN_CODE[{sym_eff, 1'b0}];
      pn_q     = PN_CODE[{sym_eff, 1'b1}];
      term_i   = pn_i ? -ext_i : ext_i;
      term_q   = pn_q ? -ext_q : ext_q;
      acc_next = acc_base + term_i + term_q;

      last_sym  = (sym_eff == LAST_SYM);
      dec_bit   = acc_next[ACC_W-1];
      byte_next = {byte_base, dec_bit};
   end

`ifdef DESPREAD_METRIC_EN
   logic [ACC_W-2:0] mag, min_q, min_d;
   logic signed [ACC_W-1:0] acc_abs;

   always_comb begin
      acc_abs = acc_next[ACC_W-1] ? -acc_next : acc_next;
      mag     = acc_abs[ACC_W-2:0];
      min_d   = ((bit_base == 3'd0) || (mag < min_q)) ? mag : min_q;
   end

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         min_q    <= '0;
         o_metric <= '0;
      end else if (process && last_sym) begin
         min_q <= min_d;
         if (bit_base == 3'd7) o_metric <= min_d;
      end
   end
`endif

   always_ff @(posedge i_clk) begin
      if (!i_reset) begin
         state_q        <= StIdle;
         acc_q          <= '0;
         sym_cnt_q      <= '0;
         bit_cnt_q      <= 3'd0;
         shift_q        <= 7'd0;
         o_data         <= 8'h00;
         o_valid_output <= 1'b0;
         o_resync       <= 1'b0;
      end else begin
         state_q  <= state_d;
         o_resync <= resync_d;
         if (i_ready_output) o_valid_output <= 1'b0;
         if (process) begin
            if (last_sym) begin
               acc_q     <= '0;
               sym_cnt_q <= '0;
               bit_cnt_q <= bit_base + 3'd1;
               shift_q   <= byte_next[6:0];
               if (bit_base == 3'd7) begin
                  shift_q        <= 7'd0;
                  o_data         <= byte_next;
                  o_valid_output <= 1'b1;
               end
            end else begin
               acc_q     <= acc_next;
               sym_cnt_q <= sym_eff + SYM_W'(1);
               bit_cnt_q <= bit_base;
               shift_q   <= byte_base;
            end
         end
      end
   end

endmodule

// File: tb/tb_qpsk_despreader.sv
// Scoreboard bench for qpsk_despreader: directed bytes pushed to a queue, monitor pops on handshake.
module tb_qpsk_despreader;

   logic        clk = 1'b0;
   logic        i_reset;
   logic [31:0] i_data;
   logic        i_valid_input, i_sof, o_ready, o_valid_output, i_ready_output, o_resync;
   logic [7:0]  o_data;
`ifdef DESPREAD_METRIC_EN
   logic [19:0] o_metric;
`endif

   always #5 clk = ~clk;

   qpsk_despreader dut (
      .i_clk          (clk),
      .i_reset        (i_reset),
      .i_data         (i_data),
      .i_valid_input  (i_valid_input),
      .i_sof          (i_sof),
      .o_ready        (o_ready),
      .o_data         (o_data),
      .o_valid_output (o_valid_output),
      .i_ready_output (i_ready_output),
      .o_resync       (o_resync)
`ifdef DESPREAD_METRIC_EN
      ,
      .o_metric       (o_metric)
`endif
   );

   int          total = 0;
   int          bad = 0;
   logic [7:0]  exp_q[$];
   int          exp_lo[$];
   int          exp_hi[$];
   int          resync_cnt = 0;
   int          sample_idx = 0;
   int          stall_cycles = 0;
   int          stall_bad = 0;
   bit          track_stall = 0;
   logic [23:0] pn_v = 24'hB38E51;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
      total++;
      if (got !== want) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, got, want);
      end
   endtask

   // Monitor: values are stable from here until the next rising edge.
   always begin
      @(negedge clk);
      #2;
      if (o_resync === 1'b1) resync_cnt++;
      if (o_valid_output === 1'b1 && i_ready_output === 1'b1) begin
         logic [7:0] e;
         int lo, hi;
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL byte_unexpected: got %h want none", o_data);
         end else begin
            e  = exp_q.pop_front();
            lo = exp_lo.pop_front();
            hi = exp_hi.pop_front();
            if (o_data !== e) begin
               bad++;
               $display("FAIL byte: got %h want %h", o_data, e);
            end
`ifdef DESPREAD_METRIC_EN
            total++;
            if (int'(o_metric) < lo || int'(o_metric) > hi) begin
               bad++;
               $display("FAIL metric: got %0d want %0d..%0d", o_metric, lo, hi);
            end
`else
            if (lo > hi) $display("note: bad metric window %0d..%0d", lo, hi);
`endif
         end
      end
   end

   function automatic logic [15:0] chip_val(input logic b, input logic pn, input int mode);
      int   v;
      logic neg;
      neg = b ^ pn;
      case (mode)
         1: v = neg ? -32768 : 32767;
         3: v = 0;
         default: begin
            v = neg ? -1000 : 1000;
            if (mode == 2) v += int'($urandom_range(1800, 0)) - 900;
         end
      endcase
      return 16'(v);
   endfunction

   task automatic send(input logic [15:0] si, input logic [15:0] sq, input logic sof);
      int guard;
      guard = 0;
      @(negedge clk);
      i_data        = {si, sq};
      i_valid_input = 1'b1;
      i_sof         = sof;
      #1;
      while (o_ready !== 1'b1) begin
         if (track_stall) begin
            stall_cycles++;
            if (sample_idx != 191) stall_bad++;
         end
         guard++;
         if (guard > 500) begin
            total++;
            bad++;
            $display("FAIL stall_timeout: got o_ready=%b want 1", o_ready);
            break;
         end
         @(negedge clk);
         #1;
      end
      @(posedge clk);
      sample_idx++;
   endtask

   task automatic idle();
      @(negedge clk);
      i_valid_input = 1'b0;
      i_sof         = 1'b0;
   endtask

   // mode: 0 clean +-1000, 1 full scale, 2 noisy, 3 all zero
   task automatic send_byte(input logic [7:0] b, input int mode, input logic sof, input int nsym,
                            input bit push, input int lo, input int hi);
      if (push) begin
         exp_q.push_back(b);
         exp_lo.push_back(lo);
         exp_hi.push_back(hi);
      end
      for (int j = 0; j < 8; j++) begin
         for (int s = 0; s < 12; s++) begin
            if (j * 12 + s < nsym) begin
               logic bv;
               bv = b[7-j];
               send(chip_val(bv, pn_v[2*s], mode), chip_val(bv, pn_v[2*s+1], mode),
                    sof && j == 0 && s == 0);
            end
         end
      end
   endtask

   task automatic drain();
      int guard;
      guard = 0;
      while (exp_q.size() != 0 && guard < 400) begin
         @(negedge clk);
         guard++;
      end
      if (exp_q.size() != 0) begin
         total++;
         bad++;
         $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
      end
      repeat (4) @(negedge clk);
   endtask

   initial begin
      i_reset        = 1'b0;
      i_valid_input  = 1'b0;
      i_sof          = 1'b0;
      i_data         = '0;
      i_ready_output = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      #1;
      check("rst_ready", {31'd0, o_ready}, 32'd1);
      check("rst_valid", {31'd0, o_valid_output}, 32'd0);
      check("rst_data", {24'd0, o_data}, 32'd0);
      check("rst_resync", {31'd0, o_resync}, 32'd0);
      i_reset = 1'b1;

      // Clean byte, single-cycle output latency
      send_byte(8'hA5, 0, 1'b1, 96, 1, 24000, 24000);
      #1;
      check("latency", {31'd0, o_valid_output}, 32'd1);
      idle();
      drain();

      // Back-pressure: only the byte-2 completing sample may stall
      @(negedge clk);
      i_ready_output = 1'b0;
      sample_idx     = 0;
      track_stall    = 1;
      fork
         begin
            send_byte(8'h00, 0, 1'b1, 96, 1, 24000, 24000);
            send_byte(8'hFF, 0, 1'b0, 96, 1, 24000, 24000);
            send_byte(8'h3C, 0, 1'b0, 96, 1, 24000, 24000);
            idle();
         end
         begin
            int g;
            g = 0;
            while (o_valid_output !== 1'b1 && g < 400) begin
               @(negedge clk);
               g++;
            end
            repeat (120) @(negedge clk);
            i_ready_output = 1'b1;
         end
      join
      track_stall = 0;
      drain();
      check("stall_seen", {31'd0, stall_cycles > 0}, 32'd1);
      check("stall_other", stall_bad, 32'd0);

      // Mid-byte frame restart
      send_byte(8'hE7, 0, 1'b1, 40, 0, 0, 0);
      send_byte(8'h81, 0, 1'b1, 96, 1, 24000, 24000);
      idle();
      drain();
      check("resync_once", resync_cnt, 32'd1);

      // Reset mid-byte, unframed samples ignored, then clean frame
      send_byte(8'h33, 0, 1'b1, 50, 0, 0, 0);
      idle();
      i_reset = 1'b0;
      @(negedge clk);
      #1;
      check("mid_rst_valid", {31'd0, o_valid_output}, 32'd0);
      check("mid_rst_data", {24'd0, o_data}, 32'd0);
      check("mid_rst_resync", {31'd0, o_resync}, 32'd0);
      i_reset = 1'b1;
      send_byte(8'hA5, 0, 1'b0, 60, 0, 0, 0);
      idle();
      repeat (5) @(negedge clk);
      send_byte(8'h5A, 0, 1'b1, 96, 1, 24000, 24000);
      idle();
      drain();

      // Full-scale inputs and exact ties
      send_byte(8'hFF, 1, 1'b1, 96, 1, 786420, 786420);
      send_byte(8'h96, 1, 1'b0, 96, 1, 786420, 786420);
      send_byte(8'h00, 3, 1'b0, 96, 1, 0, 0);
      idle();
      drain();

      // Noisy byte
      send_byte(8'hC3, 2, 1'b1, 96, 1, 1, 24000);
      idle();
      drain();

      check("queue_empty", exp_q.size(), 32'd0);
      check("resync_total", resync_cnt, 32'd1);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: got running want finished");
      $fatal(1);
   end

endmodule
